// File: rtl/handle_pkg.sv
// Shared definitions for the handle sequencer, the translation stage and benches:
// default widths, CPU/handle op codes, the reserved NONE_ID and the H_OP address encoding.
package handle_pkg;

    localparam int unsigned ADDR_WIDTH = 64;
    localparam int unsigned HNDL_WIDTH = 15;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_READ  = 3'd1;
    localparam logic [2:0] OP_WRITE = 3'd2;

    // All-ones id is never handed out; the stage returns it to signal a full table.
    localparam logic [HNDL_WIDTH-1:0] NONE_ID = '1;

    // StCheck is only reachable when ALLOC_READBACK_EN is defined.
    typedef enum logic [2:0] {
        StIdle,
        StQuery,
        StMap,
        StCheck,
        StFree,
        StResp
    } state_e;

    // Handle-command address: top bit set, next HNDL_WIDTH bits all ones, id in the low bits.
    function automatic logic [ADDR_WIDTH-1:0] h_op(input logic [HNDL_WIDTH-1:0] id);
        logic [ADDR_WIDTH-1:0] addr;
        addr                              = '0;
        addr[ADDR_WIDTH-1]                = 1'b1;
        addr[ADDR_WIDTH-2 -: HNDL_WIDTH]  = '1;
        addr[HNDL_WIDTH-1:0]              = id;
        return addr;
    endfunction

endpackage

// File: rtl/handle_cmd_fmt.sv
// Combinational command formatter: maps sequencer state, id and base onto the
// translation-stage op/address/data bus; forwards the CPU bus when idle.
module handle_cmd_fmt #(
    parameter int unsigned ADDR_WIDTH = handle_pkg::ADDR_WIDTH,
    parameter int unsigned HNDL_WIDTH = handle_pkg::HNDL_WIDTH
) (
    input  handle_pkg::state_e                 state_i,
    input  logic [HNDL_WIDTH-1:0]              id_i,
    input  logic [ADDR_WIDTH-HNDL_WIDTH-1:0]   base_i,
    input  logic [2:0]                         cpu_op_i,
    input  logic [ADDR_WIDTH-1:0]              cpu_address_i,
    input  logic [ADDR_WIDTH-1:0]              cpu_data_i,
    output logic [2:0]                         op_o,
    output logic [ADDR_WIDTH-1:0]              address_o,
    output logic [ADDR_WIDTH-1:0]              data_o
);
    import handle_pkg::*;

    logic [ADDR_WIDTH-1:0] hop_id;
    logic [ADDR_WIDTH-1:0] hop_base;

    // Build H_OP(id) / H_OP(NONE) and select the command for the current state.
    always_comb begin
        hop_id                              = '0;
        hop_id[ADDR_WIDTH-1]                = 1'b1;
        hop_id[ADDR_WIDTH-2 -: HNDL_WIDTH]  = '1;
        hop_id[HNDL_WIDTH-1:0]              = id_i;
        hop_base                            = hop_id;
        hop_base[HNDL_WIDTH-1:0]            = '1;

        op_o      = OP_NOP;
        address_o = '0;
        data_o    = '0;
        unique case (state_i)
            StIdle: begin
                op_o      = cpu_op_i;
                address_o = cpu_address_i;
                data_o    = cpu_data_i;
            end
            StQuery: begin
                op_o      = OP_READ;
                address_o = hop_base;
            end
            StMap: begin
                op_o      = OP_WRITE;
                address_o = hop_id;
                data_o    = ADDR_WIDTH'(base_i);
            end
            StCheck: begin
                op_o      = OP_READ;
                address_o = hop_id;
            end
            StFree: begin
                op_o      = OP_WRITE;
                address_o = hop_id;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/handle_alloc_seq.sv
// Handle allocate/free sequencer in front of the handle translation stage.
// Shares the stage's op/address/data bus with CPU traffic, stalling the CPU while busy.
// Optional: define ALLOC_READBACK_EN to read the mapping back after MAP and undo it on mismatch.
module handle_alloc_seq #(
    parameter int unsigned ADDR_WIDTH = handle_pkg::ADDR_WIDTH,
    parameter int unsigned HNDL_WIDTH = handle_pkg::HNDL_WIDTH
) (
    input  logic                             i_clock,
    input  logic                             i_reset,
    input  logic                             i_req_valid,
    output logic                             o_req_ready,
    input  logic                             i_req_kind,
    input  logic [ADDR_WIDTH-HNDL_WIDTH-1:0] i_req_base,
    input  logic [HNDL_WIDTH-1:0]            i_req_handle,
    output logic                             o_rsp_valid,
    input  logic                             i_rsp_ready,
    output logic [HNDL_WIDTH-1:0]            o_rsp_handle,
    output logic                             o_rsp_error,
    input  logic [2:0]                       i_op,
    input  logic [ADDR_WIDTH-1:0]            i_address,
    input  logic [ADDR_WIDTH-1:0]            i_data,
    output logic                             o_cpu_stall,
    output logic [2:0]                       o_op,
    output logic [ADDR_WIDTH-1:0]            o_address,
    output logic [ADDR_WIDTH-1:0]            o_data,
    input  logic [ADDR_WIDTH-1:0]            i_hh_data
);
    import handle_pkg::*;

    localparam int unsigned BASE_WIDTH = ADDR_WIDTH - HNDL_WIDTH;
    localparam logic [HNDL_WIDTH-1:0] HNDL_NONE = '1;

    state_e                  state_q;
    logic [HNDL_WIDTH-1:0]   id_q;
    logic [BASE_WIDTH-1:0]   base_q;
    logic                    err_pend_q;
    logic                    rsp_valid_q;
    logic [HNDL_WIDTH-1:0]   rsp_handle_q;
    logic                    rsp_error_q;
    logic                    stall_q;

    logic [2:0]              fmt_op;
    logic [ADDR_WIDTH-1:0]   fmt_address;
    logic [ADDR_WIDTH-1:0]   fmt_data;
    logic                    unused_hh;

    // Upper result bits are don't-care for this block.
    assign unused_hh = ^i_hh_data;

    // Sequencer FSM with registered response and stall outputs.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q      <= StIdle;
            id_q         <= '0;
            base_q       <= '0;
            err_pend_q   <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_handle_q <= '0;
            rsp_error_q  <= 1'b0;
            stall_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_req_valid) begin
                        stall_q    <= 1'b1;
                        err_pend_q <= 1'b0;
                        if (!i_req_kind) begin
                            base_q <= i_req_base;
                            if (i_req_base == '0) begin
                                state_q      <= StResp;
                                rsp_valid_q  <= 1'b1;
                                rsp_handle_q <= HNDL_NONE;
                                rsp_error_q  <= 1'b1;
                            end else begin
                                state_q <= StQuery;
                            end
                        end else begin
                            id_q <= i_req_handle;
                            if (i_req_handle == HNDL_NONE) begin
                                state_q      <= StResp;
                                rsp_valid_q  <= 1'b1;
                                rsp_handle_q <= i_req_handle;
                                rsp_error_q  <= 1'b1;
                            end else begin
                                state_q <= StFree;
                            end
                        end
                    end
                end
                StQuery: begin
                    // The stage reserves the returned id as a side effect of this read.
                    id_q <= i_hh_data[HNDL_WIDTH-1:0];
                    if (i_hh_data[HNDL_WIDTH-1:0] == HNDL_NONE) begin
                        state_q      <= StResp;
                        rsp_valid_q  <= 1'b1;
                        rsp_handle_q <= HNDL_NONE;
                        rsp_error_q  <= 1'b1;
                    end else begin
                        state_q <= StMap;
                    end
                end
                StMap: begin
`ifdef ALLOC_READBACK_EN
                    state_q <= StCheck;
`else
                    state_q      <= StResp;
                    rsp_valid_q  <= 1'b1;
                    rsp_handle_q <= id_q;
                    rsp_error_q  <= 1'b0;
`endif
                end
                StCheck: begin
`ifdef ALLOC_READBACK_EN
                    if (i_hh_data[BASE_WIDTH-1:0] == base_q) begin
                        state_q      <= StResp;
                        rsp_valid_q  <= 1'b1;
                        rsp_handle_q <= id_q;
                        rsp_error_q  <= 1'b0;
                    end else begin
                        // Bad mapping: release the id before reporting the error.
                        err_pend_q <= 1'b1;
                        state_q    <= StFree;
                    end
`else
                    state_q <= StIdle;
`endif
                end
                StFree: begin
                    state_q      <= StResp;
                    rsp_valid_q  <= 1'b1;
                    rsp_handle_q <= id_q;
                    rsp_error_q  <= err_pend_q;
                end
                StResp: begin
                    if (i_rsp_ready) begin
                        state_q     <= StIdle;
                        rsp_valid_q <= 1'b0;
                        stall_q     <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    handle_cmd_fmt #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .HNDL_WIDTH (HNDL_WIDTH)
    ) u_fmt (
        .state_i       (state_q),
        .id_i          (id_q),
        .base_i        (base_q),
        .cpu_op_i      (i_op),
        .cpu_address_i (i_address),
        .cpu_data_i    (i_data),
        .op_o          (fmt_op),
        .address_o     (fmt_address),
        .data_o        (fmt_data)
    );

    // Outputs are forced to their reset values for as long as reset is held.
    always_comb begin
        o_req_ready  = !i_reset && (state_q == StIdle);
        o_rsp_valid  = !i_reset && rsp_valid_q;
        o_rsp_handle = i_reset ? '0 : rsp_handle_q;
        o_rsp_error  = !i_reset && rsp_error_q;
        o_cpu_stall  = !i_reset && stall_q;
        o_op         = i_reset ? OP_NOP : fmt_op;
        o_address    = i_reset ? '0 : fmt_address;
        o_data       = i_reset ? '0 : fmt_data;
    end

endmodule

// File: tb/tb_handle_alloc_seq.sv
// Bench for handle_alloc_seq: directed vectors; responses checked by a scoreboard monitor.
module tb_handle_alloc_seq;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_kind;
    logic [48:0] req_base;
    logic [14:0] req_handle;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [14:0] rsp_handle;
    logic        rsp_error;
    logic [2:0]  cpu_op;
    logic [63:0] cpu_addr;
    logic [63:0] cpu_data;
    logic        cpu_stall;
    logic [2:0]  op;
    logic [63:0] addr;
    logic [63:0] data;
    logic [63:0] hh_data;

    typedef struct packed {
        logic [14:0] handle;
        logic        error;
    } rsp_t;

    rsp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    handle_alloc_seq dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_kind   (req_kind),
        .i_req_base   (req_base),
        .i_req_handle (req_handle),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_handle (rsp_handle),
        .o_rsp_error  (rsp_error),
        .i_op         (cpu_op),
        .i_address    (cpu_addr),
        .i_data       (cpu_data),
        .o_cpu_stall  (cpu_stall),
        .o_op         (op),
        .o_address    (addr),
        .o_data       (data),
        .i_hh_data    (hh_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cmd(string name, logic [2:0] e_op, logic [63:0] e_addr, logic [63:0] e_data);
        chk({name, "_op"}, 64'(op), 64'(e_op));
        chk({name, "_addr"}, addr, e_addr);
        chk({name, "_data"}, data, e_data);
    endtask

    task automatic issue(logic kind, logic [48:0] base, logic [14:0] hnd, rsp_t exp);
        req_valid  = 1'b1;
        req_kind   = kind;
        req_base   = base;
        req_handle = hnd;
        sb.push_back(exp);
    endtask

    // Monitor: every response handshake must match the oldest expected response.
    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rsp_unexpected: actual=%0h/%0b required=none", rsp_handle, rsp_error);
            end else begin
                rsp_t e;
                e = sb.pop_front();
                chk("rsp_handle", 64'(rsp_handle), 64'(e.handle));
                chk("rsp_error", 64'(rsp_error), 64'(e.error));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_kind = 1'b0; req_base = '0; req_handle = '0;
        rsp_ready = 1'b1; cpu_op = 3'd0; cpu_addr = '0; cpu_data = '0; hh_data = '0;

        // Reset values while reset is held.
        step();
        cpu_op = 3'd2; cpu_addr = 64'hABCD; cpu_data = 64'h77;
        #1;
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_valid", 64'(rsp_valid), 64'd0);
        chk("rst_handle", 64'(rsp_handle), 64'd0);
        chk("rst_error", 64'(rsp_error), 64'd0);
        chk("rst_stall", 64'(cpu_stall), 64'd0);
        chk_cmd("rst", 3'd0, 64'd0, 64'd0);
        step();
        rst = 1'b0;
        #1;
        chk("idle_ready", 64'(req_ready), 64'd1);
        chk_cmd("idle_fwd", 3'd2, 64'hABCD, 64'h77);
        cpu_op = 3'd0; cpu_addr = '0; cpu_data = '0;

        // Alloc base 0x10 into an empty table: id 0.
        step();
        issue(1'b0, 49'h10, 15'd0, '{handle: 15'd0, error: 1'b0});
        #1;
        chk("a1_ready", 64'(req_ready), 64'd1);
        chk("a1_stall0", 64'(cpu_stall), 64'd0);
        step();
        req_valid = 1'b0; hh_data = 64'd0;
        #1;
        chk_cmd("a1_query", 3'd1, 64'hFFFF_0000_0000_7FFF, 64'd0);
        chk("a1_stall1", 64'(cpu_stall), 64'd1);
        step();
        #1;
        chk_cmd("a1_map", 3'd2, 64'hFFFF_0000_0000_0000, 64'h10);
`ifdef ALLOC_READBACK_EN
        step();
        hh_data = 64'h10;
        #1;
        chk_cmd("a1_check", 3'd1, 64'hFFFF_0000_0000_0000, 64'd0);
`endif
        step();
        #1;
        chk("a1_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("a1_rsp_op", 64'(op), 64'd0);
        step();
        #1;
        chk("a1_done_stall", 64'(cpu_stall), 64'd0);
        chk("a1_done_valid", 64'(rsp_valid), 64'd0);

        // Alloc into a full table: no WRITE, error.
        issue(1'b0, 49'h20, 15'd0, '{handle: 15'h7FFF, error: 1'b1});
        step();
        req_valid = 1'b0; hh_data = 64'h7FFF;
        #1;
        chk_cmd("full_query", 3'd1, 64'hFFFF_0000_0000_7FFF, 64'd0);
        step();
        hh_data = 64'd0;
        #1;
        chk("full_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("full_no_write", 64'(op), 64'd0);

        // Free handle 2.
        step();
        issue(1'b1, 49'd0, 15'd2, '{handle: 15'd2, error: 1'b0});
        step();
        req_valid = 1'b0;
        #1;
        chk_cmd("free2", 3'd2, 64'hFFFF_0000_0000_0002, 64'd0);
        step();
        #1;
        chk("free2_rsp_valid", 64'(rsp_valid), 64'd1);

        // Free of the reserved id: immediate error, no command.
        step();
        issue(1'b1, 49'd0, 15'h7FFF, '{handle: 15'h7FFF, error: 1'b1});
        step();
        req_valid = 1'b0;
        #1;
        chk("freebad_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("freebad_op", 64'(op), 64'd0);

        // Alloc with base 0: immediate error.
        step();
        issue(1'b0, 49'd0, 15'd0, '{handle: 15'h7FFF, error: 1'b1});
        step();
        req_valid = 1'b0;
        #1;
        chk("base0_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("base0_op", 64'(op), 64'd0);

        // CPU READ held across an alloc with a stalled response.
        step();
        rsp_ready = 1'b0;
        cpu_op = 3'd1; cpu_addr = 64'h1234; cpu_data = 64'h55;
        issue(1'b0, 49'h30, 15'd0, '{handle: 15'd5, error: 1'b0});
        #1;
        chk_cmd("cpu_fwd0", 3'd1, 64'h1234, 64'h55);
        chk("cpu_stall0", 64'(cpu_stall), 64'd0);
        step();
        req_valid = 1'b0; hh_data = 64'd5;
        #1;
        chk("cpu_stall_q", 64'(cpu_stall), 64'd1);
        chk_cmd("cpu_query", 3'd1, 64'hFFFF_0000_0000_7FFF, 64'd0);
        step();
        hh_data = 64'd0;
        #1;
        chk_cmd("cpu_map", 3'd2, 64'hFFFF_0000_0000_0005, 64'h30);
`ifdef ALLOC_READBACK_EN
        step();
        hh_data = 64'h30;
        #1;
`endif
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            chk("cpu_hold_stall", 64'(cpu_stall), 64'd1);
            chk("cpu_hold_op", 64'(op), 64'd0);
            chk("cpu_hold_valid", 64'(rsp_valid), 64'd1);
            chk("cpu_hold_handle", 64'(rsp_handle), 64'd5);
        end
        step();
        rsp_ready = 1'b1;
        #1;
        chk("cpu_hs_valid", 64'(rsp_valid), 64'd1);
        step();
        #1;
        chk("cpu_after_stall", 64'(cpu_stall), 64'd0);
        chk_cmd("cpu_after_fwd", 3'd1, 64'h1234, 64'h55);
        cpu_op = 3'd0; cpu_addr = '0; cpu_data = '0;

        // Reset asserted during MAP abandons the sequence.
        step();
        issue(1'b0, 49'h40, 15'd0, '{handle: 15'd0, error: 1'b0});
        void'(sb.pop_back());
        step();
        req_valid = 1'b0; hh_data = 64'd7;
        step();
        hh_data = 64'd0; rst = 1'b1;
        #1;
        chk_cmd("mrst", 3'd0, 64'd0, 64'd0);
        chk("mrst_ready", 64'(req_ready), 64'd0);
        chk("mrst_stall", 64'(cpu_stall), 64'd0);
        chk("mrst_valid", 64'(rsp_valid), 64'd0);
        step();
        rst = 1'b0;
        #1;
        chk("mrst_idle_ready", 64'(req_ready), 64'd1);
        chk("mrst_idle_stall", 64'(cpu_stall), 64'd0);
        step();
        #1;
        chk("mrst_no_rsp", 64'(rsp_valid), 64'd0);

`ifdef ALLOC_READBACK_EN
        // Readback mismatch: free the id, report an error with that id.
        issue(1'b0, 49'h10, 15'd0, '{handle: 15'd9, error: 1'b1});
        step();
        req_valid = 1'b0; hh_data = 64'd9;
        step();
        hh_data = 64'd0;
        #1;
        chk_cmd("rb_map", 3'd2, 64'hFFFF_0000_0000_0009, 64'h10);
        step();
        hh_data = 64'h11;
        #1;
        chk_cmd("rb_check", 3'd1, 64'hFFFF_0000_0000_0009, 64'd0);
        step();
        hh_data = 64'd0;
        #1;
        chk_cmd("rb_free", 3'd2, 64'hFFFF_0000_0000_0009, 64'd0);
        step();
        #1;
        chk("rb_rsp_valid", 64'(rsp_valid), 64'd1);
        step();
`endif

        step();
        chk("sb_drain", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
